// File: rtl/regbank_pkg.sv
// Shared definitions for the parametrised register bank: memory FSM states and select-space layout.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } fsm_state_t;

  // Select-space layout: GPRs from 0, then input ports, then output ports, then W.
  function automatic int in_base_of(input int num_gpr);
    return num_gpr;
  endfunction

  function automatic int out_base_of(input int num_gpr, input int num_in);
    return num_gpr + num_in;
  endfunction

  function automatic int w_addr_of(input int num_gpr, input int num_in, input int num_out);
    return num_gpr + num_in + num_out;
  endfunction

  // Layout for the default configuration (28 GPR, 2 in, 2 out).
  localparam int IN_BASE  = in_base_of(28);
  localparam int OUT_BASE = out_base_of(28, 2);
  localparam int W_ADDR   = w_addr_of(28, 2, 2);

endpackage

// File: rtl/regbank_mem_fsm.sv
// Req/ack FSM moving the working register W to/from data memory; owns mem_req/mem_we/mem_wdata.
// Latency: request registered on the edge after mem_rd/mem_wr; W load strobe on the mem_ack cycle.
// Backpressure: holds mem_req until mem_ack with no timeout; new mem_rd/mem_wr ignored while busy.
// Ports: clk/rst_n (sync, active low); mem_rd/mem_wr pulses; mem_ack; w_val (current W);
//        mem_req/mem_we/mem_wdata to memory; busy; w_load tells the top to capture mem_rdata.
module regbank_mem_fsm
  import regbank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] w_val,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             w_load
);

  fsm_state_t state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Store has priority; a simultaneous load request is dropped.
          // w_val is the pre-edge W, so a same-cycle write to W is not stored.
          if (mem_wr) begin
            state_q   <= STORE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= w_val;
            busy      <= 1'b1;
          end else if (mem_rd) begin
            state_q <= LOAD;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD, STORE: begin
          if (mem_ack) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign w_load = (state_q == LOAD) && mem_ack;

endmodule

// File: rtl/param_register_bank.sv
// Register bank: NUM_GPR GPRs, NUM_IN registered inputs, NUM_OUT outputs and W on one select space.
// Latency: reads combinational, writes at the clock edge, inputs seen one cycle after pi changes.
// Backpressure: writes to W dropped while a memory transfer is busy; other writes always land.
// Ports: sel_a/sel_b -> data_a/data_b reads; sel_c/data_c/wr_c write; pi in, po out, w_out;
//        mem_* req/ack memory interface and busy from regbank_mem_fsm.
// Build option: define REGBANK_FWD_EN for same-cycle write-through on the read ports.
module param_register_bank
  import regbank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_GPR = 28,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           sel_a,
  input  logic [SEL_W-1:0]           sel_b,
  output logic [WIDTH-1:0]           data_a,
  output logic [WIDTH-1:0]           data_b,
  input  logic [SEL_W-1:0]           sel_c,
  input  logic [WIDTH-1:0]           data_c,
  input  logic                       wr_c,
  input  logic [NUM_IN*WIDTH-1:0]    pi,
  output logic [NUM_OUT*WIDTH-1:0]   po,
  output logic [WIDTH-1:0]           w_out,
  input  logic                       mem_rd,
  input  logic                       mem_wr,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WIDTH-1:0]           mem_wdata,
  input  logic [WIDTH-1:0]           mem_rdata,
  input  logic                       mem_ack,
  output logic                       busy
);

  localparam int IN_B  = in_base_of(NUM_GPR);
  localparam int OUT_B = out_base_of(NUM_GPR, NUM_IN);
  localparam int W_A   = w_addr_of(NUM_GPR, NUM_IN, NUM_OUT);

  localparam logic [SEL_W-1:0] IN_S  = SEL_W'(IN_B);
  localparam logic [SEL_W-1:0] OUT_S = SEL_W'(OUT_B);
  localparam logic [SEL_W-1:0] W_S   = SEL_W'(W_A);

  logic [WIDTH-1:0] gpr_q [NUM_GPR];
  logic [WIDTH-1:0] pi_q  [NUM_IN];
  logic [WIDTH-1:0] po_q  [NUM_OUT];
  logic [WIDTH-1:0] w_q;
  logic             w_load;

  // Write target decode; input addresses and anything above W are not writable.
  logic sel_c_gpr, sel_c_po, sel_c_w, writable_c;
  assign sel_c_gpr  = (sel_c < IN_S);
  assign sel_c_po   = (sel_c >= OUT_S) && (sel_c < W_S);
  assign sel_c_w    = (sel_c == W_S) && !busy;
  assign writable_c = sel_c_gpr || sel_c_po || sel_c_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      for (int i = 0; i < NUM_IN; i++)  pi_q[i]  <= '0;
      for (int i = 0; i < NUM_OUT; i++) po_q[i]  <= '0;
      w_q <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) pi_q[i] <= pi[i*WIDTH +: WIDTH];
      for (int i = 0; i < NUM_GPR; i++)
        if (wr_c && sel_c == SEL_W'(i)) gpr_q[i] <= data_c;
      for (int i = 0; i < NUM_OUT; i++)
        if (wr_c && sel_c == SEL_W'(OUT_B + i)) po_q[i] <= data_c;
      // A load can only complete while busy, when CPU writes to W are blocked.
      if (w_load)
        w_q <= mem_rdata;
      else if (wr_c && sel_c_w)
        w_q <= data_c;
    end
  end

  function automatic logic [WIDTH-1:0] read_sel(input logic [SEL_W-1:0] sel);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_GPR; i++) if (sel == SEL_W'(i))         v = gpr_q[i];
    for (int i = 0; i < NUM_IN; i++)  if (sel == SEL_W'(IN_B + i))  v = pi_q[i];
    for (int i = 0; i < NUM_OUT; i++) if (sel == SEL_W'(OUT_B + i)) v = po_q[i];
    if (sel == W_S) v = w_q;
    return v;
  endfunction

  always_comb begin
    data_a = read_sel(sel_a);
    data_b = read_sel(sel_b);
`ifdef REGBANK_FWD_EN
    if (wr_c && writable_c && sel_a == sel_c) data_a = data_c;
    if (wr_c && writable_c && sel_b == sel_c) data_b = data_c;
`endif
  end

  always_comb begin
    po = '0;
    for (int i = 0; i < NUM_OUT; i++) po[i*WIDTH +: WIDTH] = po_q[i];
  end

  assign w_out = w_q;

  regbank_mem_fsm #(.WIDTH(WIDTH)) u_mem_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .w_val     (w_q),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .w_load    (w_load)
  );

endmodule

// File: tb/tb_param_register_bank.sv
module tb_param_register_bank;

  localparam int WIDTH = 16;
  localparam int SEL_W = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [SEL_W-1:0]   sel_a, sel_b, sel_c;
  logic [WIDTH-1:0]   data_a, data_b, data_c;
  logic               wr_c;
  logic [2*WIDTH-1:0] pi;
  logic [2*WIDTH-1:0] po;
  logic [WIDTH-1:0]   w_out;
  logic               mem_rd, mem_wr, mem_req, mem_we, mem_ack, busy;
  logic [WIDTH-1:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_register_bank dut (
    .clk(clk), .rst_n(rst_n),
    .sel_a(sel_a), .sel_b(sel_b), .data_a(data_a), .data_b(data_b),
    .sel_c(sel_c), .data_c(data_c), .wr_c(wr_c),
    .pi(pi), .po(po), .w_out(w_out),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  // Advance past one rising edge, leaving time to drive and settle before the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    for (int s = 0; s < 40; s++) begin
      sel_a = SEL_W'(s);
      #1;
      checks++;
      if (data_a !== 16'h0) begin
        $display("FAIL reset_read sel=%0d got=%h exp=0000", s, data_a); errors++;
      end
    end
    checks++;
    if (po !== 32'h0) begin $display("FAIL reset_po got=%h exp=0", po); errors++; end
    checks++;
    if (w_out !== 16'h0) begin $display("FAIL reset_w got=%h exp=0", w_out); errors++; end
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      $display("FAIL reset_fsm req=%b busy=%b we=%b exp=000", mem_req, busy, mem_we); errors++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_forward();
    // GPR 7 is still zero from reset.
    wr_c = 1'b1; sel_c = 6'd7; data_c = 16'h4242; sel_a = 6'd7;
    #1;
    checks++;
`ifdef REGBANK_FWD_EN
    if (data_a !== 16'h4242) begin $display("FAIL fwd_bypass got=%h exp=4242", data_a); errors++; end
`else
    if (data_a !== 16'h0000) begin $display("FAIL fwd_nobypass got=%h exp=0000", data_a); errors++; end
`endif
    step();
    wr_c = 1'b0;
    #1;
    checks++;
    if (data_a !== 16'h4242) begin $display("FAIL fwd_after got=%h exp=4242", data_a); errors++; end
  endtask

  task automatic test_write_read();
    wr_c = 1'b1; sel_c = 6'd5; data_c = 16'hBEEF;
    step();
    wr_c = 1'b0; data_c = 16'h1111; sel_a = 6'd5;
    #1;
    checks++;
    if (data_a !== 16'hBEEF) begin $display("FAIL gpr5 got=%h exp=BEEF", data_a); errors++; end
    step();
    checks++;
    if (data_a !== 16'hBEEF) begin $display("FAIL no_wr_en got=%h exp=BEEF", data_a); errors++; end
    // Highest GPR, read through port B.
    wr_c = 1'b1; sel_c = 6'd27; data_c = 16'h2727;
    step();
    wr_c = 1'b0; sel_b = 6'd27;
    #1;
    checks++;
    if (data_b !== 16'h2727) begin $display("FAIL gpr27 got=%h exp=2727", data_b); errors++; end
    // Output ports.
    wr_c = 1'b1; sel_c = 6'd30; data_c = 16'hC0DE;
    step();
    sel_c = 6'd31; data_c = 16'hF00D;
    step();
    wr_c = 1'b0; sel_a = 6'd31;
    #1;
    checks++;
    if (po !== 32'hF00D_C0DE) begin $display("FAIL po got=%h exp=F00DC0DE", po); errors++; end
    checks++;
    if (data_a !== 16'hF00D) begin $display("FAIL po_read got=%h exp=F00D", data_a); errors++; end
    // Addresses above W are ignored on write and read as zero.
    wr_c = 1'b1; sel_c = 6'd33; data_c = 16'hDEAD;
    step();
    sel_c = 6'd63;
    step();
    wr_c = 1'b0; sel_a = 6'd33; sel_b = 6'd5;
    #1;
    checks++;
    if (data_a !== 16'h0 || data_b !== 16'hBEEF || po !== 32'hF00D_C0DE || w_out !== 16'h0) begin
      $display("FAIL out_of_range a=%h b=%h po=%h w=%h exp=0000/BEEF/F00DC0DE/0000",
               data_a, data_b, po, w_out);
      errors++;
    end
  endtask

  task automatic test_input();
    pi = {16'h9999, 16'h1234}; sel_b = 6'd28; sel_a = 6'd29;
    #1;
    checks++;
    if (data_b !== 16'h0) begin $display("FAIL pi_latency got=%h exp=0000", data_b); errors++; end
    step();
    checks++;
    if (data_b !== 16'h1234) begin $display("FAIL pi0 got=%h exp=1234", data_b); errors++; end
    checks++;
    if (data_a !== 16'h9999) begin $display("FAIL pi1 got=%h exp=9999", data_a); errors++; end
    wr_c = 1'b1; sel_c = 6'd28; data_c = 16'hFFFF;
    step();
    wr_c = 1'b0;
    #1;
    checks++;
    if (data_b !== 16'h1234) begin $display("FAIL pi_readonly got=%h exp=1234", data_b); errors++; end
  endtask

  task automatic test_store();
    wr_c = 1'b1; sel_c = 6'd32; data_c = 16'h00AA;
    step();
    wr_c = 1'b0;
    mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h00AA || busy !== 1'b1) begin
      $display("FAIL store_req req=%b we=%b wdata=%h busy=%b exp=1/1/00AA/1",
               mem_req, mem_we, mem_wdata, busy);
      errors++;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_wdata !== 16'h00AA) begin
        $display("FAIL store_hold cyc=%0d req=%b wdata=%h exp=1/00AA", k, mem_req, mem_wdata);
        errors++;
      end
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL store_done req=%b busy=%b exp=0/0", mem_req, busy); errors++;
    end
    // Store accepted on the same edge as a CPU write to W: old W goes to memory.
    mem_wr = 1'b1; wr_c = 1'b1; sel_c = 6'd32; data_c = 16'h7777;
    step();
    mem_wr = 1'b0; wr_c = 1'b0;
    checks++;
    if (mem_wdata !== 16'h00AA || w_out !== 16'h7777) begin
      $display("FAIL store_same_cycle wdata=%h w=%h exp=00AA/7777", mem_wdata, w_out); errors++;
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_load();
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL load_req req=%b we=%b busy=%b exp=1/0/1", mem_req, mem_we, busy); errors++;
    end
    // W write dropped while busy; GPR write still lands; mem_wr ignored.
    wr_c = 1'b1; sel_c = 6'd32; data_c = 16'h1357; mem_wr = 1'b1;
    step();
    sel_c = 6'd3; data_c = 16'h3333; mem_wr = 1'b0;
    step();
    wr_c = 1'b0; sel_a = 6'd3;
    #1;
    checks++;
    if (w_out !== 16'h7777) begin $display("FAIL w_busy_drop got=%h exp=7777", w_out); errors++; end
    checks++;
    if (data_a !== 16'h3333) begin $display("FAIL gpr_busy_wr got=%h exp=3333", data_a); errors++; end
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
      $display("FAIL load_hold we=%b req=%b exp=0/1", mem_we, mem_req); errors++;
    end
    mem_rdata = 16'h5A5A; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (w_out !== 16'h5A5A || mem_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL load_done w=%h req=%b busy=%b exp=5A5A/0/0", w_out, mem_req, busy); errors++;
    end
    // Stray ack in IDLE must not load W.
    mem_rdata = 16'hFFFF; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (w_out !== 16'h5A5A || busy !== 1'b0) begin
      $display("FAIL idle_ack w=%h busy=%b exp=5A5A/0", w_out, busy); errors++;
    end
    // Simultaneous load and store requests: store wins.
    mem_rd = 1'b1; mem_wr = 1'b1;
    step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 16'h5A5A) begin
      $display("FAIL store_priority we=%b wdata=%h exp=1/5A5A", mem_we, mem_wdata); errors++;
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    checks++;
    if (busy !== 1'b1) begin $display("FAIL mid_busy got=%b exp=1", busy); errors++; end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || w_out !== 16'h0) begin
      $display("FAIL mid_reset req=%b busy=%b w=%h exp=0/0/0000", mem_req, busy, w_out); errors++;
    end
    mem_rdata = 16'hABCD; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (w_out !== 16'h0 || busy !== 1'b0) begin
      $display("FAIL late_ack w=%h busy=%b exp=0000/0", w_out, busy); errors++;
    end
  endtask

  initial begin
    rst_n = 1'b0; sel_a = '0; sel_b = '0; sel_c = '0; data_c = '0; wr_c = 1'b0;
    pi = '0; mem_rd = 1'b0; mem_wr = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_forward();
    test_write_read();
    test_input();
    test_store();
    test_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
